// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int INSTR_BYTES  = 4;
  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of PC-tagged instruction words between memory and decode.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  FIFO_DEPTH = 2,
  parameter type ENTRY_T    = fetch_entry_t
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic                      i_flush,
  input  ENTRY_T                    i_data,
  output ENTRY_T                    o_head,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                      o_empty,
  output logic                      o_full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ENTRY_T             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_rdPtr;
  logic [PTR_W-1:0]   r_wrPtr;
  logic [CNT_W-1:0]   r_count;
  logic               w_doPush;
  logic               w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPush = i_push && !i_flush && (!o_full || i_pop);
  assign w_doPop  = i_pop && !i_flush && !o_empty;

  // Pointer and occupancy bookkeeping; a flush empties the buffer in one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: stale slots are never visible past the pointers.
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the fetch PC, issues one word request per cycle to a
// fixed 1-cycle-latency memory, tags returned words with their PC and buffers
// them for decode. A redirect flushes the buffer and drops the word in flight.
// Optional macro FETCH_ALIGN_CHK_EN: a misaligned redirect target traps into a
// sticky FAULT state; without it the low two target bits are simply cleared.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int                       FIFO_DEPTH    = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_fetch_en,
  input  logic                     i_redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_redirect_pc,
  output logic                     o_mem_req,
  output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0]    i_mem_rdata,
  output logic                     o_instr_valid,
  output logic [DATA_WIDTH-1:0]    o_instr,
  output logic [ADDRESS_WIDTH-1:0] o_instr_pc,
  input  logic                     i_instr_ready,
  output logic                     o_fetch_fault
);

  localparam int                       CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int                       OCC_W = CNT_W + 1;
  localparam logic [ADDRESS_WIDTH-1:0] STEP  = ADDRESS_WIDTH'(INSTR_BYTES);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } entry_t;

  fetch_state_t             r_state;
  fetch_state_t             w_stateNext;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [ADDRESS_WIDTH-1:0] w_pcNext;
  logic                     r_inflight;
  logic [ADDRESS_WIDTH-1:0] r_inflightPc;
  logic [ADDRESS_WIDTH-1:0] w_redirPc;
  logic                     w_misaligned;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_popReq;
  logic                     w_flush;
  logic                     w_empty;
  logic                     w_full;
  logic [CNT_W-1:0]         w_count;
  logic [OCC_W-1:0]         w_occupancy;
  logic                     w_hasCredit;
  entry_t                   w_pushEntry;
  entry_t                   w_head;

`ifdef FETCH_ALIGN_CHK_EN
  assign w_redirPc     = i_redirect_pc;
  assign w_misaligned  = |i_redirect_pc[1:0];
  assign o_fetch_fault = (r_state == FAULT);
`else
  assign w_redirPc     = i_redirect_pc & ~ADDRESS_WIDTH'(INSTR_BYTES - 1);
  assign w_misaligned  = 1'b0;
  assign o_fetch_fault = 1'b0;
`endif

  // Credit: a new request is allowed only if every word already owed a slot
  // (buffered plus in flight, minus the one leaving now) still leaves room.
  assign o_instr_valid = (r_state == RUN) && !w_empty;
  assign w_popReq      = o_instr_valid && i_instr_ready;
  assign w_occupancy   = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_popReq);
  assign w_hasCredit   = (w_occupancy < OCC_W'(FIFO_DEPTH));
  assign w_pushEntry   = {r_inflightPc, i_mem_rdata};
  assign o_instr       = o_instr_valid ? w_head.instr : '0;
  assign o_instr_pc    = o_instr_valid ? w_head.pc    : '0;

  fetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ENTRY_T    (entry_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_pushEntry),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Next state, next PC, request issue and buffer control; redirect outranks all.
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_flush     = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_addr  = r_pc;
    case (r_state)
      BOOT: begin
        w_stateNext = RUN;
        if (i_redirect_valid) w_pcNext = w_redirPc;
      end
      RUN: begin
        if (i_redirect_valid) begin
          w_flush    = 1'b1;
          o_mem_addr = w_redirPc;
          if (w_misaligned) begin
            w_stateNext = FAULT;
          end else begin
            o_mem_req = i_fetch_en;
            w_pcNext  = i_fetch_en ? (w_redirPc + STEP) : w_redirPc;
          end
        end else begin
          w_pop     = w_popReq;
          w_push    = r_inflight && (!w_full || w_popReq);
          o_mem_req = i_fetch_en && w_hasCredit;
          if (i_fetch_en && w_hasCredit) w_pcNext = r_pc + STEP;
        end
      end
      FAULT: begin
        w_stateNext = FAULT;
      end
      default: begin
        w_stateNext = BOOT;
      end
    endcase
  end

  // State, PC and in-flight tracking; reset drops any word still owed by memory.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_inflight   <= 1'b0;
      r_inflightPc <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_pc       <= w_pcNext;
      r_inflight <= o_mem_req;
      if (o_mem_req) r_inflightPc <= o_mem_addr;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a PC scoreboard; a second instance
// starts near the top of the address space to exercise PC wraparound.
module tb_fetch_controller;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_ready;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          fetch_fault;

  logic          redirect_valid2 = 1'b0;
  logic [AW-1:0] redirect_pc2 = '0;
  logic          instr_ready2 = 1'b1;
  logic          mem_req2;
  logic [AW-1:0] mem_addr2;
  logic [DW-1:0] mem_rdata2;
  logic          instr_valid2;
  logic [DW-1:0] instr2;
  logic [AW-1:0] instr_pc2;
  logic          fetch_fault2;

  int            passCount = 0;
  int            checkCount = 0;
  logic [AW-1:0] expQ[$];

  always #5 clk = ~clk;

  fetch_controller dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_fetch_en       (fetch_en),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_mem_req        (mem_req),
    .o_mem_addr       (mem_addr),
    .i_mem_rdata      (mem_rdata),
    .o_instr_valid    (instr_valid),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc),
    .i_instr_ready    (instr_ready),
    .o_fetch_fault    (fetch_fault)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_fetch_en       (fetch_en),
    .i_redirect_valid (redirect_valid2),
    .i_redirect_pc    (redirect_pc2),
    .o_mem_req        (mem_req2),
    .o_mem_addr       (mem_addr2),
    .i_mem_rdata      (mem_rdata2),
    .o_instr_valid    (instr_valid2),
    .o_instr          (instr2),
    .o_instr_pc       (instr_pc2),
    .i_instr_ready    (instr_ready2),
    .o_fetch_fault    (fetch_fault2)
  );

  // Memory contents are a fixed function of the byte address.
  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  // Fixed one-cycle-latency instruction memory for both instances.
  always @(posedge clk) begin
    mem_rdata  <= memWord(mem_addr);
    mem_rdata2 <= memWord(mem_addr2);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Drive one cycle's inputs just after the edge, then let outputs settle.
  task automatic applyStimulus(input logic en, input logic rv, input logic [AW-1:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    fetch_en       = en;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    #2;
  endtask

  // Every accepted word must be the next expected PC with its memory word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1 && redirect_valid === 1'b0) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected word: got pc 0x%0h, expected no word", instr_pc);
      end else begin
        logic [AW-1:0] expPc;
        expPc = expQ.pop_front();
        checkOutput("instr_pc", 64'(instr_pc), 64'(expPc));
        checkOutput("instr", 64'(instr), 64'(memWord(expPc)));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] wrapAddr [4];
    wrapAddr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    repeat (3) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("reset mem_req", 64'(mem_req), 64'd0);
    checkOutput("reset instr_valid", 64'(instr_valid), 64'd0);
    checkOutput("reset fetch_fault", 64'(fetch_fault), 64'd0);
    checkOutput("reset instr_pc", 64'(instr_pc), 64'd0);

    // Cycle 0 (BOOT): no request yet.
    rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
    #1;
    checkOutput("boot mem_req", 64'(mem_req), 64'd0);

    // Straight-line fetch from address 0.
    expQ.push_back(32'h0); expQ.push_back(32'h4);
    expQ.push_back(32'h8); expQ.push_back(32'hC);
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      checkOutput("seq mem_req", 64'(mem_req), 64'd1);
      checkOutput("seq mem_addr", 64'(mem_addr), 64'((c - 1) * 4));
      checkOutput("wrap mem_addr", 64'(mem_addr2), 64'(wrapAddr[c-1]));
      if (c <= 2) checkOutput("first valid timing", 64'(instr_valid), 64'd0);
      if (c == 3) checkOutput("wrap instr_pc", 64'(instr_pc2), 64'h0000_0000_FFFF_FFF8);
      if (c == 4) checkOutput("wrap instr_pc", 64'(instr_pc2), 64'h0000_0000_FFFF_FFFC);
    end

    // Decode stalls for five cycles: requests stop, head holds.
    for (int c = 5; c <= 9; c++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0);
      if (c == 5) checkOutput("wrap instr_pc", 64'(instr_pc2), 64'd0);
      checkOutput("stall mem_req", 64'(mem_req), 64'd0);
      checkOutput("stall instr_valid", 64'(instr_valid), 64'd1);
      checkOutput("stall instr_pc", 64'(instr_pc), 64'h8);
      checkOutput("stall instr", 64'(instr), 64'(memWord(32'h8)));
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("release mem_req", 64'(mem_req), 64'd1);
    checkOutput("release mem_addr", 64'(mem_addr), 64'h10);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("release mem_addr", 64'(mem_addr), 64'h14);

    // Redirect with 0x10 buffered and 0x14 in flight.
    expQ.push_back(32'h100); expQ.push_back(32'h104);
    expQ.push_back(32'h108); expQ.push_back(32'h10C);
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b1);
    checkOutput("redirect mem_req", 64'(mem_req), 64'd1);
    checkOutput("redirect mem_addr", 64'(mem_addr), 64'h100);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("post-redirect flushed", 64'(instr_valid), 64'd0);
    checkOutput("post-redirect mem_addr", 64'(mem_addr), 64'h104);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);

    // fetch_en drops with a word in flight: remaining words drain, then idle.
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("drain mem_req", 64'(mem_req), 64'd0);
    checkOutput("drain instr_valid", 64'(instr_valid), 64'd1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("drained instr_valid", 64'(instr_valid), 64'd0);
    checkOutput("drained mem_req", 64'(mem_req), 64'd0);

    // Misaligned redirect target.
    applyStimulus(1'b1, 1'b1, 32'h102, 1'b1);
`ifdef FETCH_ALIGN_CHK_EN
    checkOutput("misaligned mem_req", 64'(mem_req), 64'd0);
    for (int c = 20; c <= 23; c++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      checkOutput("fault flag", 64'(fetch_fault), 64'd1);
      checkOutput("fault mem_req", 64'(mem_req), 64'd0);
      checkOutput("fault instr_valid", 64'(instr_valid), 64'd0);
    end
`else
    expQ.push_back(32'h100); expQ.push_back(32'h104);
    checkOutput("misaligned mem_req", 64'(mem_req), 64'd1);
    checkOutput("misaligned mem_addr", 64'(mem_addr), 64'h100);
    applyStimulus(1'b1, 1'b0, '0, 1'b1);
    checkOutput("no fault", 64'(fetch_fault), 64'd0);
    checkOutput("aligned resume addr", 64'(mem_addr), 64'h104);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("resume drained", 64'(instr_valid), 64'd0);
`endif

    // Reset in the middle of activity discards buffered and in-flight words.
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("mid reset mem_req", 64'(mem_req), 64'd0);
    checkOutput("mid reset instr_valid", 64'(instr_valid), 64'd0);
    checkOutput("mid reset fetch_fault", 64'(fetch_fault), 64'd0);
    rst_n = 1'b1;
    #1;
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("restart instr_valid", 64'(instr_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("restart instr_valid", 64'(instr_valid), 64'd1);
    checkOutput("restart instr_pc", 64'(instr_pc), 64'd0);
    checkOutput("restart instr", 64'(instr), 64'(memWord(32'h0)));

    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
